// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: RISC-V M-extension
// multiply modes and the sequencer state encoding.
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mul_digit_step.sv
// One radix-2^DIGIT partial-product accumulation: hi + mcand * digit.
module mul_digit_step #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic [WIDTH+DIGIT-1:0] hi,
  input  logic [WIDTH-1:0]       mcand,
  input  logic [DIGIT-1:0]       digit,
  output logic [WIDTH+DIGIT-1:0] sum
);

  assign sum = hi + ((WIDTH+DIGIT)'(mcand) * (WIDTH+DIGIT)'(digit));

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative sign/magnitude multiplier for MUL/MULH/MULHSU/MULHU, retiring
// DIGIT multiplier bits per cycle with a fixed latency of WIDTH/DIGIT + 2.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             op_q;
  logic                   neg_q;
  logic [WIDTH-1:0]       mcand_q;
  logic [WIDTH+DIGIT-1:0] hi_q;
  logic [WIDTH-1:0]       lo_q;
  logic [WIDTH-1:0]       result_q;

  logic                   load;
  logic                   signed_a, signed_b, neg_a, neg_b;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH+DIGIT-1:0] sum;
  logic [2*WIDTH-1:0]     product, product_fix;

  assign load = start && !kill && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    signed_a = (op == OP_MULH) || (op == OP_MULHSU);
    signed_b = (op == OP_MULH);
    neg_a    = signed_a && a[WIDTH-1];
    neg_b    = signed_b && b[WIDTH-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
  end

  mul_digit_step #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) u_step (
    .hi   (hi_q),
    .mcand(mcand_q),
    .digit(lo_q[DIGIT-1:0]),
    .sum  (sum)
  );

  // Negating the full double-width product keeps MUL's low half correct too.
  always_comb begin
    product     = {hi_q[WIDTH-1:0], lo_q};
    product_fix = neg_q ? -product : product;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = start ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else if (load) begin
      cnt_q   <= '0;
      op_q    <= op;
      neg_q   <= neg_a ^ neg_b;
      mcand_q <= mag_a;
      hi_q    <= '0;
      lo_q    <= mag_b;
    end else if (!kill) begin
      if (state_q == S_CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
        hi_q  <= sum >> DIGIT;
        lo_q  <= {sum[DIGIT-1:0], lo_q[WIDTH-1:DIGIT]};
      end
      if (state_q == S_FIX) begin
        result_q <= (op_q == OP_MUL) ? product_fix[WIDTH-1:0]
                                     : product_fix[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed and randomised checks of mul_iter_unit at 64/4 and 32/1.
module tb_mul_iter_unit;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, kill;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  logic        start32, kill32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [31:0] result32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_iter_unit #(.WIDTH(64), .DIGIT(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  mul_iter_unit #(.WIDTH(32), .DIGIT(1)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .kill(kill32), .busy(busy32), .done(done32), .result(result32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle number of the done pulse (cycle 1 follows the start edge).
  task automatic waitDone(input bit wide, output int lat, output int busy_cnt);
    lat = 1; busy_cnt = 0;
    while (((wide ? done : done32) !== 1'b1) && lat < 100) begin
      if ((wide ? busy : busy32) === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [31:0] refMul32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] p;
    sx = (o == OP_MULH || o == OP_MULHSU) ? {{32{x[31]}}, x} : {32'b0, x};
    sy = (o == OP_MULH) ? {{32{y[31]}}, y} : {32'b0, y};
    p  = sx * sy;
    return (o == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  initial begin
    int lat, bc, dones;
    logic [1:0]  o;
    logic [31:0] x, y;

    reset = 1'b1; start = 1'b0; kill = 1'b0; op = OP_MUL; a = '0; b = '0;
    start32 = 1'b0; kill32 = 1'b0; op32 = OP_MUL; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_result", result, 64'd0);

    applyStimulus(OP_MUL, 64'd3, 64'd5);
    waitDone(1'b1, lat, bc);
    checkOutput("mul_latency", 64'(lat), 64'd18);
    checkOutput("mul_busy_cycles", 64'(bc), 64'd17);
    checkOutput("mul_busy_in_done", 64'(busy), 64'd0);
    checkOutput("mul_3x5", result, 64'd15);

    applyStimulus(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    waitDone(1'b1, lat, bc);
    checkOutput("mulh_m1xm1", result, 64'd0);

    applyStimulus(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    waitDone(1'b1, lat, bc);
    checkOutput("mulhu_max", result, 64'hFFFF_FFFF_FFFF_FFFE);

    applyStimulus(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    waitDone(1'b1, lat, bc);
    checkOutput("mulhsu_m1x2", result, 64'hFFFF_FFFF_FFFF_FFFF);

    applyStimulus(OP_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    waitDone(1'b1, lat, bc);
    checkOutput("mulh_minxmin", result, 64'h4000_0000_0000_0000);

    applyStimulus(OP_MUL, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3);
    waitDone(1'b1, lat, bc);
    checkOutput("mul_m7x3", result, 64'hFFFF_FFFF_FFFF_FFEB);

    applyStimulus(OP_MUL, 64'd6, 64'd7);
    waitDone(1'b1, lat, bc);
    checkOutput("mul_6x7", result, 64'd42);
    @(posedge clk); #1;

    // Second op: stray start in CALC cycle 3, kill in CALC cycle 5.
    applyStimulus(OP_MULHU, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    @(posedge clk); #1;
    @(posedge clk); #1;
    op = OP_MUL; a = 64'd100; b = 64'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("kill_busy", 64'(busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checkOutput("kill_no_done", 64'(dones), 64'd0);
    checkOutput("kill_result_kept", result, 64'd42);

    op = OP_MUL; a = 64'd5; b = 64'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    checkOutput("kill_over_start", 64'(busy), 64'd0);

    applyStimulus(OP_MUL, 64'd2, 64'd3);
    waitDone(1'b1, lat, bc);
    checkOutput("b2b_first", result, 64'd6);
    applyStimulus(OP_MUL, 64'd10, 64'd10);
    waitDone(1'b1, lat, bc);
    checkOutput("b2b_latency", 64'(lat), 64'd18);
    checkOutput("b2b_second", result, 64'd100);

    applyStimulus(OP_MULHU, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF);
    repeat (4) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    checkOutput("async_rst_done", 64'(done), 64'd0);
    checkOutput("async_rst_result", result, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    applyStimulus(OP_MUL, 64'd9, 64'd9);
    waitDone(1'b1, lat, bc);
    checkOutput("post_rst_latency", 64'(lat), 64'd18);
    checkOutput("post_rst_9x9", result, 64'd81);

    for (int i = 0; i < 800; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 16 == 1) x = 32'h8000_0000;
      if (i % 16 == 2) y = 32'hFFFF_FFFF;
      if (i % 16 == 3) begin x = 32'h8000_0000; y = 32'h8000_0000; end
      if (i % 16 == 4) x = 32'd0;
      op32 = o; a32 = x; b32 = y; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      waitDone(1'b0, lat, bc);
      if (i == 0) checkOutput("w32_latency", 64'(lat), 64'd34);
      checkOutput($sformatf("w32_rnd%0d_op%0d", i, o), 64'(result32), 64'(refMul32(o, x, y)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
